branch_predictor: RTL and testbench

- Bimodal branch history table (BHT) of 2-bit saturating counters.
- Fetch stage queries it combinationally with the fetch PC and receives a taken/not-taken prediction.
- EX stage writes back the resolved outcome: br_en from the branch comparator, plus the funct3 and the prediction carried down the pipe.
- The block trains the table, flags mispredictions one cycle later for pipeline redirect/flush, and keeps saturating performance counters.

---
 rtl/branch_predictor.sv | 83 ++++++++
 tb/tb_branch_predictor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch history table of 2-bit saturating counters with registered
// mispredict / illegal-funct3 pulses and saturating performance counters.
module branch_predictor #(
   parameter int IDX_BITS  = 6,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          fetch_pc,
   output logic                 pred_taken,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic [2:0]           upd_funct3,
   input  logic                 upd_br_en,
   input  logic                 upd_pred_taken,
   output logic                 mispredict,
   output logic                 illegal_branch,
   output logic [CNT_WIDTH-1:0] br_count,
   output logic [CNT_WIDTH-1:0] mispred_count
);

   localparam int                   ENTRIES = 1 << IDX_BITS;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]           r_bht [ENTRIES];
   logic                 r_mispredict;
   logic                 r_illegal;
   logic [CNT_WIDTH-1:0] r_br_count;
   logic [CNT_WIDTH-1:0] r_mispred_count;

   logic [IDX_BITS-1:0]  w_fetch_idx;
   logic [IDX_BITS-1:0]  w_upd_idx;
   logic                 w_illegal;
   logic                 w_legal;
   logic                 w_mispred;
   logic                 w_unused;

   assign w_fetch_idx = fetch_pc[IDX_BITS+1:2];
   assign w_upd_idx   = upd_pc[IDX_BITS+1:2];
   assign w_illegal   = upd_valid && (upd_funct3 == 3'b010 || upd_funct3 == 3'b011);
   assign w_legal     = upd_valid && !w_illegal;
   assign w_mispred   = w_legal && (upd_br_en != upd_pred_taken);

   // Upper PC bits alias by design and the low two bits are byte offset.
   assign w_unused = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0],
                       upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

   // Read is the pre-update value: no write-to-read bypass.
   assign pred_taken     = rst_n & r_bht[w_fetch_idx][1];
   assign mispredict     = r_mispredict;
   assign illegal_branch = r_illegal;
   assign br_count       = r_br_count;
   assign mispred_count  = r_mispred_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_bht[i] <= 2'b01;
         end
         r_mispredict    <= 1'b0;
         r_illegal       <= 1'b0;
         r_br_count      <= '0;
         r_mispred_count <= '0;
      end else begin
         r_mispredict <= w_mispred;
         r_illegal    <= w_illegal;
         if (w_legal) begin
            if (upd_br_en && r_bht[w_upd_idx] != 2'b11) begin
               r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'd1;
            end else if (!upd_br_en && r_bht[w_upd_idx] != 2'b00) begin
               r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'd1;
            end
            if (!(&r_br_count)) begin
               r_br_count <= r_br_count + CNT_ONE;
            end
            if (w_mispred && !(&r_mispred_count)) begin
               r_mispred_count <= r_mispred_count + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed plan items plus random traffic checked
// against an integer reference model; a second 4-bit-counter instance shares stimulus.
module tb_branch_predictor;

   localparam int IDX_BITS = 6;
   localparam int ENTRIES  = 1 << IDX_BITS;

   logic        clk;
   logic        rst_n;
   logic [31:0] fetch_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [2:0]  upd_funct3;
   logic        upd_br_en;
   logic        upd_pred_taken;

   logic        pred_taken, pred_taken4;
   logic        mispredict, mispredict4;
   logic        illegal_branch, illegal_branch4;
   logic [31:0] br_count, mispred_count;
   logic [3:0]  br_count4, mispred_count4;

   int          n_checks;
   int          n_errors;

   // reference model state
   int          bht_m [ENTRIES];
   longint      br_m, mis_m;
   int          br4_m, mis4_m;
   logic [1:0]  exp_q [$];

   branch_predictor #(.IDX_BITS(IDX_BITS), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_funct3(upd_funct3),
      .upd_br_en(upd_br_en), .upd_pred_taken(upd_pred_taken),
      .mispredict(mispredict), .illegal_branch(illegal_branch),
      .br_count(br_count), .mispred_count(mispred_count)
   );

   branch_predictor #(.IDX_BITS(IDX_BITS), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken4),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_funct3(upd_funct3),
      .upd_br_en(upd_br_en), .upd_pred_taken(upd_pred_taken),
      .mispredict(mispredict4), .illegal_branch(illegal_branch4),
      .br_count(br_count4), .mispred_count(mispred_count4)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) bht_m[i] = 1;
      br_m = 0; mis_m = 0; br4_m = 0; mis4_m = 0;
      exp_q.delete();
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return int'(pc >> 2) % ENTRIES;
   endfunction

   task automatic check_counts(input string tag);
      check({tag, ".br_count"}, br_count, br_m);
      check({tag, ".mispred_count"}, mispred_count, mis_m);
      check({tag, ".br_count4"}, br_count4, br4_m);
      check({tag, ".mispred_count4"}, mispred_count4, mis4_m);
   endtask

   // driver: one full cycle of stimulus with pre-edge prediction check and post-edge output checks
   task automatic drive_cycle(input logic v, input logic [31:0] pc, input logic [2:0] f3,
                              input logic be, input logic pt, input logic [31:0] fpc);
      logic       ill, legal, mis;
      logic [1:0] exp;
      int         ui;
      @(negedge clk);
      upd_valid = v; upd_pc = pc; upd_funct3 = f3;
      upd_br_en = be; upd_pred_taken = pt; fetch_pc = fpc;
      #1;
      check("pred_taken", pred_taken, bht_m[idx_of(fpc)] >= 2);
      check("pred_taken4", pred_taken4, bht_m[idx_of(fpc)] >= 2);
      ill   = v && (f3 == 3'd2 || f3 == 3'd3);
      legal = v && !ill;
      mis   = legal && (be != pt);
      @(posedge clk);
      if (legal) begin
         ui = idx_of(pc);
         bht_m[ui] = be ? ((bht_m[ui] + 1 > 3) ? 3 : bht_m[ui] + 1)
                        : ((bht_m[ui] - 1 < 0) ? 0 : bht_m[ui] - 1);
         if (br_m < 64'hFFFF_FFFF) br_m++;
         if (br4_m < 15) br4_m++;
         if (mis) begin
            if (mis_m < 64'hFFFF_FFFF) mis_m++;
            if (mis4_m < 15) mis4_m++;
         end
      end
      exp_q.push_back({ill, mis});
      #1;
      exp = exp_q.pop_front();
      check("mispredict", mispredict, exp[0]);
      check("illegal_branch", illegal_branch, exp[1]);
      check("mispredict4", mispredict4, exp[0]);
      check_counts("cyc");
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      upd_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; fetch_pc = 32'h40; upd_valid = 1'b0; upd_pc = '0;
      upd_funct3 = '0; upd_br_en = 1'b0; upd_pred_taken = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst.pred_taken", pred_taken, 0);
      check("rst.mispredict", mispredict, 0);
      check("rst.illegal_branch", illegal_branch, 0);
      check_counts("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // three taken updates from weak NT, prediction said not-taken
      for (int k = 0; k < 3; k++) drive_cycle(1, 32'h40, 3'b000, 1, 0, 32'h40);
      drive_cycle(0, 32'h0, 3'b000, 0, 0, 32'h40);
      check("plan.br_count3", br_count, 3);
      check("plan.mispred3", mispred_count, 3);

      // four not-taken updates from strong T, prediction said taken
      for (int k = 0; k < 4; k++) drive_cycle(1, 32'h40, 3'b001, 0, 1, 32'h40);
      drive_cycle(0, 32'h0, 3'b000, 0, 0, 32'h40);
      check("plan.mispred7", mispred_count, 7);

      // illegal funct3: pulse only, nothing else changes
      drive_cycle(1, 32'h80, 3'b011, 1, 0, 32'h80);
      check("plan.illegal_pulse", illegal_branch, 1);
      drive_cycle(0, 32'h0, 3'b000, 0, 0, 32'h80);
      check("plan.illegal_drop", illegal_branch, 0);
      drive_cycle(1, 32'h84, 3'b010, 0, 1, 32'h80);

      // alias + same-cycle read: old value this cycle, new value next cycle
      do_reset();
      drive_cycle(1, 32'h140, 3'b100, 1, 0, 32'h40);
      check("alias.pred_next", pred_taken, 1);
      drive_cycle(0, 32'h0, 3'b000, 0, 0, 32'h40);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         logic [31:0] rpc, rfpc;
         logic [2:0]  rf3;
         logic        rv, rbe, rpt;
         rv   = ($urandom_range(0, 3) != 0);
         rpc  = $urandom & 32'hFFFF_FF0C;
         rpc[IDX_BITS+1:2] = 6'($urandom_range(0, 7));
         rfpc = $urandom;
         rfpc[IDX_BITS+1:2] = 6'($urandom_range(0, 7));
         rf3  = 3'($urandom_range(0, 7));
         rbe  = ($urandom_range(0, 2) != 0);
         rpt  = $urandom_range(0, 1) ? (bht_m[idx_of(rpc)] >= 2) : 1'($urandom_range(0, 1));
         drive_cycle(rv, rpc, rf3, rbe, rpt, rfpc);
      end

      // async reset mid-cycle with a legal update presented
      drive_cycle(1, 32'h40, 3'b101, 1, 0, 32'h40);
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = 32'h40; upd_funct3 = 3'b000;
      upd_br_en = 1'b1; upd_pred_taken = 1'b0; fetch_pc = 32'h40;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("arst.mispredict", mispredict, 0);
      check("arst.illegal_branch", illegal_branch, 0);
      check("arst.pred_taken", pred_taken, 0);
      check_counts("arst");
      @(posedge clk);
      #1;
      check_counts("arst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      upd_valid = 1'b0;
      drive_cycle(0, 32'h0, 3'b000, 0, 0, 32'h40);
      check("arst.entry_untouched", pred_taken, 0);

      // 4-bit counter saturation
      for (int k = 0; k < 16; k++) drive_cycle(1, 32'h100, 3'b110, k[0], 0, 32'h100);
      drive_cycle(1, 32'h104, 3'b111, 1, 0, 32'h100);
      check("sat.br_count4", br_count4, 4'hF);
      check("sat.br_count32", br_count, 17);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // overall time bound
   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
